// File: rtl/seq_bin2bcd_if.sv
// Handshake and result bundle between an upstream producer, the
// binary-to-BCD converter and the display driver that consumes bcd/blank.
interface seq_bin2bcd_if #(
    parameter int W = 8,
    parameter int D = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   bin;
    logic           out_valid;
    logic [4*D-1:0] bcd;
    logic [D-1:0]   blank;

    modport master (
        output in_valid, bin,
        input  in_ready, out_valid, bcd, blank
    );

    modport slave (
        input  in_valid, bin,
        output in_ready, out_valid, bcd, blank
    );
endinterface

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds the multiplexed display driver: bcd/blank hold their value between
// completions so the display always sees a stable number.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for in_valid; in_ready high
//   CONV  | one double-dabble step per edge; last step publishes result
module seq_bin2bcd #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic          clk,
    input  logic          reset,
    seq_bin2bcd_if.slave  bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [D-1:0] BLANK_RST = {D{1'b1}} ^ D'(1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // D digits must be able to hold the largest W-bit value
    if (pow10(D) < (64'd1 << W)) begin : g_digits_too_few
        $error("seq_bin2bcd: D digits cannot represent every W-bit value");
    end

    // Digit i is blank when it and every more significant digit are zero;
    // digit 0 is always shown so a value of 0 still displays.
    function automatic logic [D-1:0] lead_zero(input logic [4*D-1:0] v);
        logic nz;
        lead_zero = '0;
        nz        = 1'b0;
        for (int i = D - 1; i >= 1; i--) begin
            nz           = nz | (v[4*i +: 4] != 4'd0);
            lead_zero[i] = ~nz;
        end
    endfunction

    typedef enum logic {IDLE, CONV} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [4*D-1:0] scratch_q, scratch_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4*D-1:0] bcd_q, bcd_d;
    logic [D-1:0]   blank_q, blank_d;
    logic           out_valid_q, out_valid_d;

    logic [4*D-1:0] adj;
    logic [4*D-1:0] step_scratch;

    // Add-3 correction on the pre-shift scratch, then shift in the next binary MSB
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < D; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        step_scratch = {adj[4*D-2:0], shift_q[W-1]};
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                shift_d   = shift_q << 1;
                scratch_d = step_scratch;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    bcd_d       = step_scratch;
                    blank_d     = lead_zero(step_scratch);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any conversion in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= BLANK_RST;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;
    assign bus.blank     = blank_q;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// Bench for seq_bin2bcd: two instances (W=8/D=3 and W=16/D=5) checked
// against a decimal-arithmetic reference.
module tb_seq_bin2bcd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8  = 1'b1;
    logic rst16 = 1'b1;

    seq_bin2bcd_if #(.W(8),  .D(3)) v8  ();
    seq_bin2bcd_if #(.W(16), .D(5)) v16 ();

    seq_bin2bcd #(.W(8),  .D(3)) dut8  (.clk(clk), .reset(rst8),  .bus(v8.slave));
    seq_bin2bcd #(.W(16), .D(5)) dut16 (.clk(clk), .reset(rst16), .bus(v16.slave));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, blanks by magnitude comparison
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
        logic [63:0] r;
        longint unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < d; i++) begin
            r = r | (64'((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_blank(input longint unsigned v, input int d);
        logic [63:0] r;
        longint unsigned p;
        r = '0;
        p = 10;
        for (int i = 1; i < d; i++) begin
            if (v < p) r[i] = 1'b1;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present v, count edges from accept to out_valid; busy_ok tracks in_ready low meanwhile
    task automatic conv8(input int v, output logic [11:0] bcd, output logic [2:0] blank,
                         output int lat, output logic busy_ok);
        int n;
        n = 0;
        while (!v8.in_ready && n < 30) begin
            tick();
            n++;
        end
        v8.in_valid = 1'b1;
        v8.bin      = 8'(v);
        tick();
        v8.in_valid = 1'b0;
        v8.bin      = 8'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        while (!v8.out_valid && lat < 30) begin
            busy_ok = busy_ok & !v8.in_ready;
            tick();
            lat++;
        end
        bcd   = v8.bcd;
        blank = v8.blank;
    endtask

    task automatic conv16(input int v, output logic [19:0] bcd, output logic [4:0] blank,
                          output int lat);
        int n;
        n = 0;
        while (!v16.in_ready && n < 40) begin
            tick();
            n++;
        end
        v16.in_valid = 1'b1;
        v16.bin      = 16'(v);
        tick();
        v16.in_valid = 1'b0;
        v16.bin      = 16'($urandom);
        lat = 0;
        while (!v16.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        bcd   = v16.bcd;
        blank = v16.blank;
    endtask

    task automatic run8(input string tag, input int v);
        logic [11:0] b;
        logic [2:0]  bl;
        int          lat;
        logic        busy;
        conv8(v, b, bl, lat, busy);
        check({tag, "_lat"},   64'(lat), 64'd8);
        check({tag, "_bcd"},   64'(b),   ref_bcd(v, 3));
        check({tag, "_blank"}, 64'(bl),  ref_blank(v, 3));
    endtask

    task automatic run16(input string tag, input int v);
        logic [19:0] b;
        logic [4:0]  bl;
        int          lat;
        conv16(v, b, bl, lat);
        check({tag, "_lat"},   64'(lat), 64'd16);
        check({tag, "_bcd"},   64'(b),   ref_bcd(v, 5));
        check({tag, "_blank"}, 64'(bl),  ref_blank(v, 5));
    endtask

    initial begin
        logic [11:0] b;
        logic [2:0]  bl;
        int          lat;
        logic        busy;
        int          acc[$];
        int          ov_e[$];
        logic [11:0] ov_v[$];
        int          order[256];
        int          seen;
        logic        rdy;
        logic        held;

        v8.in_valid  = 1'b0;
        v8.bin       = '0;
        v16.in_valid = 1'b0;
        v16.bin      = '0;
        #3;
        rst8  = 1'b0;
        rst16 = 1'b0;
        #20;

        check("rst_bcd",       64'(v8.bcd),       64'h000);
        check("rst_blank",     64'(v8.blank),     64'b110);
        check("rst_in_ready",  64'(v8.in_ready),  64'd1);
        check("rst_out_valid", 64'(v8.out_valid), 64'd0);
        check("rst16_blank",   64'(v16.blank),    64'b11110);

        tick();
        rst8  = 1'b1;
        rst16 = 1'b1;
        check("rel_bcd",   64'(v8.bcd),   64'h000);
        check("rel_blank", 64'(v8.blank), 64'b110);

        run8("v7",   7);
        run8("v10",  10);
        run8("v100", 100);
        run8("v0",   0);

        conv8(255, b, bl, lat, busy);
        check("v255_busy",  64'(busy), 64'd1);
        check("v255_lat",   64'(lat),  64'd8);
        check("v255_bcd",   64'(b),    64'h255);
        check("v255_blank", 64'(bl),   64'b000);
        check("v255_ready_with_valid", 64'(v8.in_ready), 64'd1);
        tick();
        check("v255_pulse", 64'(v8.out_valid), 64'd0);
        check("v255_hold",  64'(v8.bcd),       64'h255);

        // Back-to-back: in_valid held, bin changes while converting
        v8.in_valid = 1'b1;
        v8.bin      = 8'd42;
        for (int e = 0; e < 26; e++) begin
            rdy = v8.in_ready;
            held = v8.in_valid;
            tick();
            if (rdy && held) begin
                acc.push_back(e);
                if (acc.size() == 1) v8.bin = 8'd5;
                else v8.in_valid = 1'b0;
            end
            if (acc.size() == 1 && e == acc[0] + 3) v8.bin = 8'd199;
            if (v8.out_valid) begin
                ov_e.push_back(e);
                ov_v.push_back(v8.bcd);
            end
        end
        v8.in_valid = 1'b0;
        check("b2b_accepts", 64'(acc.size()),  64'd2);
        check("b2b_outputs", 64'(ov_e.size()), 64'd2);
        if (acc.size() == 2 && ov_e.size() == 2) begin
            check("b2b_gap",   64'(acc[1] - acc[0]),  64'd9);
            check("b2b_lat0",  64'(ov_e[0] - acc[0]), 64'd8);
            check("b2b_lat1",  64'(ov_e[1] - acc[1]), 64'd8);
            check("b2b_bcd0",  64'(ov_v[0]),          64'h042);
            check("b2b_bcd1",  64'(ov_v[1]),          64'h199);
        end

        // Reset three steps into converting 200
        v8.in_valid = 1'b1;
        v8.bin      = 8'd200;
        tick();
        v8.in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst8 = 1'b0;
        #1;
        check("mid_rst_bcd",   64'(v8.bcd),       64'h000);
        check("mid_rst_blank", 64'(v8.blank),     64'b110);
        check("mid_rst_ready", 64'(v8.in_ready),  64'd1);
        check("mid_rst_ov",    64'(v8.out_valid), 64'd0);
        tick();
        rst8 = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (v8.out_valid) seen++;
        end
        check("mid_rst_no_ov",  64'(seen),   64'd0);
        check("mid_rst_stable", 64'(v8.bcd), 64'h000);
        run8("after_rst13", 13);

        // Exhaustive W=8 sweep in shuffled order
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) run8($sformatf("sweep%0d", order[i]), order[i]);

        // Wider instance
        run16("w16_65535", 65535);
        run16("w16_9", 9);
        check("w16_9_blank_exact", 64'(v16.blank), 64'b11110);
        for (int i = 0; i < 100; i++) begin
            int v;
            v = int'($urandom_range(0, 65535));
            run16($sformatf("w16_rand%0d", v), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
